vga_scanout: RTL
================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter H_VIS, 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch in clocks.
REQ-003 Parameter V_VIS, 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync and back porch in lines.
REQ-005 Parameter SCALE_SH, 3, log2 of the square upscale factor, so each buffer pixel covers 8x8 screen pixels.
REQ-006 Parameter BUF_W, 80, buffer pixels per row (H_VIS >> SCALE_SH).
REQ-007 clk  input  1  pixel clock (25 MHz); all logic is on the rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 read_addr  output  13  frame-buffer read address, driven to the dual_port_ram read port.
REQ-010 ram_dout  input  12  frame-buffer read data (RGB444, R in [11:8]); valid exactly 1 clk after read_addr.
REQ-011 rgb  output  12  pixel colour; 0 whenever the output is blanked.
REQ-012 hsync  output  1  horizontal sync, active-low.
REQ-013 vsync  output  1  vertical sync, active-low.
REQ-014 video_on  output  1  high while rgb carries a visible pixel.
REQ-015 frame_done  output  1  one-clk pulse marking the end of the last visible line, used for upstream buffer swap.

Function
REQ-016 h_cnt counts 0..H_TOT-1 (H_TOT = 800), where H_TOT = H_VIS + H_FP + H_SYNC + H_BP; it wraps to 0 and v_cnt increments on wrap.
REQ-017 v_cnt counts 0..V_TOT-1 (V_TOT = 525) and wraps to 0 when h_cnt wraps on line V_TOT-1.
REQ-018 Stage 0: raw visible = (h_cnt < H_VIS) && (v_cnt < V_VIS); raw hsync low for h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC); raw vsync low for v_cnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC).
REQ-019 Address = (v_cnt>>SCALE_SH)*BUF_W + (h_cnt>>SCALE_SH), computed with shifts and adds only (80 = 64+16), no multiplier; read_addr registers it 1 clk after the counter state.
REQ-020 read_addr is registered to 0 whenever the raw visible flag is low; the maximum address is 4799, so there is no wrap past 13 bits.
REQ-021 ram_dout is captured into rgb 1 clk after it is valid, for a total latency of 3 clks from counter state to the rgb output.
REQ-022 Raw visible, hsync and vsync pass through a 3-stage delay line, so video_on, hsync and vsync stay aligned to rgb.
REQ-023 rgb = video_on_next ? ram_dout : 12'h000, registered.
REQ-024 frame_done pulses for 1 clk, aligned with the outputs, in the clock after the last visible pixel (639,479) leaves rgb; it is exactly one pulse per frame.
REQ-025 There are no stalls or handshake: ram_dout is sampled unconditionally, and upstream writes never block scanout.
REQ-026 The counters are free-running, with no enable and no resynchronisation other than rst.

Reset
REQ-027 While rst is high: h_cnt = v_cnt = 0, read_addr = 0, rgb = 0, video_on = 0, hsync = vsync = 1 (inactive), frame_done = 0, and all delay-line stages are cleared to these inactive values.
REQ-028 An assertion of rst mid-line or mid-frame takes effect immediately and asynchronously.
REQ-029 After rst deasserts, the counters start at (0,0) on the first rising edge, and the first visible rgb appears 3 clks later.

Verification
REQ-030 Reset then run 2 full frames: hsync has a period of 800 clks with 96 clks low; vsync has a period of 420000 clks with 1600 clks low.
REQ-031 With the RAM model at addr = data: at pixel (h=17, v=9), read_addr = 1*80 + 2 = 82, and rgb = 82 appears 3 clks after the counter reaches (17,9).
REQ-032 Boundaries: at (639,479), read_addr = 4799; at h = 640 or v = 480, read_addr = 0, rgb = 0 and video_on = 0.
REQ-033 Alignment: on every line, the first video_on high coincides with rgb = buffer[row*80], and video_on covers exactly 640 clks.
REQ-034 Assert rst at h=300, v=200, held for 7 clks: outputs take their reset values asynchronously, and after release the first hsync falls exactly 656+3 clks later.
REQ-035 Count frame_done over 3 frames: exactly 3 single-clk pulses, each 3 clks after the counters leave (639,479).

Source files
------------

// File: rtl/vga_scanout_if.sv
// Scanout bus: frame-buffer read port toward the RAM plus the timed video
// outputs toward the display.
interface vga_scanout_if;
  logic [12:0] read_addr;
  logic [11:0] ram_dout;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        frame_done;

  modport master (
    output read_addr, rgb, hsync, vsync, video_on, frame_done,
    input  ram_dout
  );

  modport slave (
    input  read_addr, rgb, hsync, vsync, video_on, frame_done,
    output ram_dout
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA timing generator and upscaling frame-buffer scanout. Each buffer pixel
// covers a (1<<SCALE_SH)-square block of screen pixels; outputs lag the counters by 3 clks.
module vga_scanout #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE_SH = 3,
  parameter int BUF_W    = 80
) (
  input logic           clk,
  input logic           rst,
  vga_scanout_if.master bus
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int AW    = 13;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_START = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
  localparam logic [VW-1:0] V_VIS_L  = VW'(V_VIS - 1);
  localparam logic [VW-1:0] VS_START = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [AW-1:0] BUF_W_C  = AW'(BUF_W);

  logic [HW-1:0] h_cnt_r;
  logic [VW-1:0] v_cnt_r;

  logic          vis_s;
  logic          hs_s;
  logic          vs_s;
  logic          fd_s;
  logic [HW-1:0] col_s;
  logic [AW-1:0] row_s;
  logic [AW-1:0] addr_s;

  logic [AW-1:0] read_addr_r;
  logic [11:0]   rgb_r;
  logic [2:0]    vis_d_r;
  logic [2:0]    hs_d_r;
  logic [2:0]    vs_d_r;
  logic [2:0]    fd_d_r;

  // Free-running pixel and line counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= '0;
      if (v_cnt_r == V_LAST) begin
        v_cnt_r <= '0;
      end else begin
        v_cnt_r <= v_cnt_r + 1'b1;
      end
    end else begin
      h_cnt_r <= h_cnt_r + 1'b1;
    end
  end

  // Stage 0: raw timing flags and buffer address from the counter state
  always_comb begin
    vis_s  = (h_cnt_r < H_VIS_C) && (v_cnt_r < V_VIS_C);
    hs_s   = !((h_cnt_r >= HS_START) && (h_cnt_r < HS_END));
    vs_s   = !((v_cnt_r >= VS_START) && (v_cnt_r < VS_END));
    // The counter sits one past the last visible pixel of the last visible line.
    fd_s   = (h_cnt_r == H_VIS_C) && (v_cnt_r == V_VIS_L);
    col_s  = h_cnt_r >> SCALE_SH;
    row_s  = AW'(v_cnt_r >> SCALE_SH);
    // row * BUF_W as a sum of shifted rows, one term per set bit of BUF_W.
    addr_s = AW'(col_s);
    for (int i = 0; i < AW; i++) begin
      if (BUF_W_C[i]) begin
        addr_s = addr_s + (row_s << i);
      end else begin
        addr_s = addr_s;
      end
    end
  end

  // Read address, pixel capture and the 3-stage timing delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_addr_r <= '0;
      rgb_r       <= 12'h000;
      vis_d_r     <= 3'b000;
      hs_d_r      <= 3'b111;
      vs_d_r      <= 3'b111;
      fd_d_r      <= 3'b000;
    end else begin
      read_addr_r <= vis_s ? addr_s : '0;
      rgb_r       <= vis_d_r[1] ? bus.ram_dout : 12'h000;
      vis_d_r     <= {vis_d_r[1:0], vis_s};
      hs_d_r      <= {hs_d_r[1:0], hs_s};
      vs_d_r      <= {vs_d_r[1:0], vs_s};
      fd_d_r      <= {fd_d_r[1:0], fd_s};
    end
  end

  assign bus.read_addr  = read_addr_r;
  assign bus.rgb        = rgb_r;
  assign bus.video_on   = vis_d_r[2];
  assign bus.hsync      = hs_d_r[2];
  assign bus.vsync      = vs_d_r[2];
  assign bus.frame_done = fd_d_r[2];

endmodule
